grf: RTL and testbench
======================

# grf

General register file for the single-cycle MIPS datapath. It sits at the receiving end of the write-back select path: the chosen destination register number (rt/rd/$ra) arrives on `a3` and the chosen write data (ALU/memory/PC+4) arrives on `wd`. It stores 32 × 32-bit registers with `$0` hardwired to zero and provides two combinational read ports to the decode/ALU stage. It also keeps a registered write-trace record and a write counter that the testbench compares against the golden instruction trace.

## Interface
- `BYPASS`, default 1: when 1, a read of the register being written this cycle returns `wd`. When 0, it returns the stored (old) value.
- `RESET_VAL`, default 32'h0000_0000: value loaded into registers 1..31 on reset.

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `we` input 1: write enable from control.
- `a1` input 5: read address, port 1 (rs).
- `a2` input 5: read address, port 2 (rt).
- `a3` input 5: write address (selected rt/rd/$ra).
- `wd` input 32: write data (selected ALU/mem/PC+4).
- `pc` input 32: PC of the instruction performing the write. Used only for the trace.
- `rd1` output 32: read data, port 1.
- `rd2` output 32: read data, port 2.
- `wr_valid` output 1: pulses high for one cycle after an effective write.
- `wr_addr` output 5: register number of the last effective write.
- `wr_data` output 32: data of the last effective write.
- `wr_pc` output 32: PC of the last effective write.
- `wr_count` output 32: number of effective writes since reset.

## Operation
- **Effective write:** `we==1 && a3!=0 && reset==0`, sampled at the rising edge. On an effective write, `reg[a3] <= wd`.
- **Writes to `$0`:** a write with `a3==0` is discarded. It does not update the trace, `wr_valid`, or `wr_count`.
- **Reads:** fully combinational.
  - `rdN = 0` when `aN==0`, in all cases.
  - Otherwise, when `BYPASS==1` and an effective write to `aN` is pending this cycle, `rdN = wd`.
  - Otherwise, `rdN = reg[aN]`.
- **Simultaneous reads:** `a1==a2==a3` with an effective write and `BYPASS=1` gives `rd1 = rd2 = wd`.
- **Trace registers:** on each effective write, `wr_addr <= a3`, `wr_data <= wd`, `wr_pc <= pc`, and `wr_valid <= 1`. On any other non-reset cycle, `wr_valid <= 0` and the other trace registers hold.
- **Counter:** `wr_count` increments by 1 per effective write. It wraps from 32'hFFFF_FFFF to 0 with no flag.
- **Register 0:** never stored. No storage bit for `$0` may affect any output.

## Timing
- **Reset:** on a rising edge with `reset==1`:
  - registers 1..31 ← `RESET_VAL`;
  - `wr_valid` ← 0, `wr_addr` ← 0, `wr_data` ← 0, `wr_pc` ← 0, `wr_count` ← 0.
  - Reset overrides a simultaneous `we`: the write is lost.
- **Reset mid-program:** reset may assert on any cycle. The cycle after reset deasserts behaves as a fresh start.
- **Write latency:** data written at edge N is visible on `rdN` via storage from after edge N. With `BYPASS=1` it is also visible combinationally in the cycle before edge N.
- **Trace latency:** `wr_*` reflect a write one cycle after it is presented, i.e. valid in the cycle following the write edge.
- **Back-to-back writes:** `wr_valid` stays high for consecutive effective writes. `wr_count` increments every cycle.
- **Read ports:** no clock dependence. Outputs settle within the same cycle as address changes.

## Test plan
1. **Reset:** hold `reset` for 2 cycles with `we=1, a3=5, wd=32'hDEAD_BEEF`, then release and read `a1=5`.
   - `rd1 = 0`, `wr_count = 0`, `wr_valid = 0`.
2. **Basic write and read-back:** write `a3=8, wd=32'h1234_5678, pc=32'h0000_3000`. Next cycle read `a1=8, a2=0`.
   - `rd1 = 32'h1234_5678`, `rd2 = 0`.
   - `wr_valid = 1`, `wr_addr = 8`, `wr_data = 32'h1234_5678`, `wr_pc = 32'h0000_3000`, `wr_count = 1`.
3. **`$0` protection:** `we=1, a3=0, wd=32'hFFFF_FFFF`, with `a1=0` during and after.
   - `rd1 = 0` in both cycles.
   - `wr_valid` stays 0 and `wr_count` is unchanged.
4. **Bypass:** `reg[31] = 32'h0000_0001`. In the same cycle present `we=1, a3=31, wd=32'h0000_3008, a1=31, a2=31`.
   - With `BYPASS=1`: `rd1 = rd2 = 32'h0000_3008` before the edge.
   - With `BYPASS=0`: `rd1 = rd2 = 32'h0000_0001` before the edge and `32'h0000_3008` after it.
5. **Back-to-back and counter:** write registers 1..31 on 31 consecutive cycles with `wd = 32'hA000_0000 + n`.
   - `wr_valid` is high for exactly 31 cycles.
   - `wr_count` ends at 31.
   - Reading every register returns its written value.
6. **Wrap:** force `wr_count` to 32'hFFFF_FFFF via hierarchical deposit, then perform one effective write.
   - `wr_count = 0`, `wr_valid = 1`.

Source files
------------

// File: rtl/grf.sv
// rtl/grf.sv - 32x32 MIPS general register file with hardwired $0, write-through reads and a write trace
module grf #(
  parameter bit          BYPASS    = 1'b1,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [4:0]  a3,
  input  logic [31:0] wd,
  input  logic [31:0] pc,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] wr_pc,
  output logic [31:0] wr_count
);

  // Entry 0 is never written and never read, so it drops out in synthesis.
  logic [31:0] regs [32];
  logic        we_eff;

  assign we_eff = we && (a3 != 5'd0) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) regs[i] <= RESET_VAL;
      wr_valid <= 1'b0;
      wr_addr  <= 5'd0;
      wr_data  <= 32'd0;
      wr_pc    <= 32'd0;
      wr_count <= 32'd0;
    end else begin
      wr_valid <= we_eff;
      if (we_eff) begin
        regs[a3] <= wd;
        wr_addr  <= a3;
        wr_data  <= wd;
        wr_pc    <= pc;
        wr_count <= wr_count + 32'd1;
      end
    end
  end

  function automatic logic [31:0] read_port(input logic [4:0] a);
    if (a == 5'd0)
      return 32'd0;
    else if (BYPASS && we_eff && (a == a3))
      return wd;
    else
      return regs[a];
  endfunction

  assign rd1 = read_port(a1);
  assign rd2 = read_port(a2);

endmodule

// File: tb/tb_grf.sv
// tb/tb_grf.sv - randomized bench for grf, both bypass variants against an array model
module tb_grf;

  logic        clk = 1'b0;
  logic        reset, we;
  logic [4:0]  a1, a2, a3;
  logic [31:0] wd, pc;

  logic [31:0] rd1_b, rd2_b, wr_data_b, wr_pc_b, wr_count_b;
  logic [31:0] rd1_n, rd2_n, wr_data_n, wr_pc_n, wr_count_n;
  logic        wr_valid_b, wr_valid_n;
  logic [4:0]  wr_addr_b, wr_addr_n;

  grf #(.BYPASS(1'b1)) dut_b (
    .clk(clk), .reset(reset), .we(we), .a1(a1), .a2(a2), .a3(a3), .wd(wd), .pc(pc),
    .rd1(rd1_b), .rd2(rd2_b), .wr_valid(wr_valid_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .wr_pc(wr_pc_b), .wr_count(wr_count_b)
  );

  grf #(.BYPASS(1'b0)) dut_n (
    .clk(clk), .reset(reset), .we(we), .a1(a1), .a2(a2), .a3(a3), .wd(wd), .pc(pc),
    .rd1(rd1_n), .rd2(rd2_n), .wr_valid(wr_valid_n), .wr_addr(wr_addr_n),
    .wr_data(wr_data_n), .wr_pc(wr_pc_n), .wr_count(wr_count_n)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: architectural registers plus the expected trace record.
  logic [31:0] m [32];
  logic        m_valid;
  logic [4:0]  m_addr;
  logic [31:0] m_data, m_pc, m_count;
  int          valid_cycles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] expect_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'd0;
    if (byp && we && !reset && a3 != 0 && a3 == a) return wd;
    return m[a];
  endfunction

  task automatic check_all();
    check("rd1_byp",   rd1_b, expect_rd(a1, 1'b1));
    check("rd2_byp",   rd2_b, expect_rd(a2, 1'b1));
    check("rd1_nobyp", rd1_n, expect_rd(a1, 1'b0));
    check("rd2_nobyp", rd2_n, expect_rd(a2, 1'b0));
    check("wr_valid",  {31'd0, wr_valid_b}, {31'd0, m_valid});
    check("wr_addr",   {27'd0, wr_addr_b},  {27'd0, m_addr});
    check("wr_data",   wr_data_b,  m_data);
    check("wr_pc",     wr_pc_b,    m_pc);
    check("wr_count",  wr_count_b, m_count);
    check("trace_nobyp", {wr_valid_n, wr_addr_n, wr_data_n[25:0]},
                         {m_valid, m_addr, m_data[25:0]});
    check("count_nobyp", wr_count_n, m_count);
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic step();
    #1 check_all();
    @(posedge clk);
    if (reset) begin
      for (int i = 1; i < 32; i++) m[i] = 32'd0;
      m_valid = 0; m_addr = 0; m_data = 0; m_pc = 0; m_count = 0;
    end else if (we && a3 != 0) begin
      m[a3] = wd; m_valid = 1; m_addr = a3; m_data = wd; m_pc = pc; m_count = m_count + 1;
    end else begin
      m_valid = 0;
    end
    @(negedge clk);
    if (wr_valid_b) valid_cycles++;
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] x1, input logic [4:0] x2,
                       input logic [4:0] x3, input logic [31:0] d, input logic [31:0] p);
    reset = r; we = w; a1 = x1; a2 = x2; a3 = x3; wd = d; pc = p;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 32'hX;
    m[0] = 32'd0;
    m_valid = 1'bx; m_addr = 'x; m_data = 'x; m_pc = 'x; m_count = 'x;
    drive(1, 1, 5, 0, 5, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk);
    // Outputs are undefined before the first reset edge, so skip checking there.
    @(posedge clk);
    for (int i = 1; i < 32; i++) m[i] = 32'd0;
    m_valid = 0; m_addr = 0; m_data = 0; m_pc = 0; m_count = 0;
    @(negedge clk);
    step();

    drive(0, 0, 5, 0, 0, 32'h0, 32'h0);
    #1 check("t1_rd1", rd1_b, 32'd0);
    check("t1_count", wr_count_b, 32'd0);
    check("t1_valid", {31'd0, wr_valid_b}, 32'd0);
    step();

    drive(0, 1, 0, 0, 8, 32'h1234_5678, 32'h0000_3000);
    step();
    drive(0, 0, 8, 0, 0, 32'h0, 32'h0);
    #1 check("t2_rd1", rd1_b, 32'h1234_5678);
    check("t2_rd2", rd2_b, 32'd0);
    check("t2_addr", {27'd0, wr_addr_b}, 32'd8);
    check("t2_pc", wr_pc_b, 32'h0000_3000);
    check("t2_count", wr_count_b, 32'd1);
    step();

    drive(0, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'h4);
    #1 check("t3_rd1_during", rd1_b, 32'd0);
    step();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    #1 check("t3_rd1_after", rd1_b, 32'd0);
    check("t3_valid", {31'd0, wr_valid_b}, 32'd0);
    check("t3_count", wr_count_b, 32'd1);
    step();

    drive(0, 1, 0, 0, 31, 32'h0000_0001, 32'h8);
    step();
    drive(0, 1, 31, 31, 31, 32'h0000_3008, 32'hC);
    #1 check("t4_byp_rd1", rd1_b, 32'h0000_3008);
    check("t4_byp_rd2", rd2_b, 32'h0000_3008);
    check("t4_nobyp_rd1", rd1_n, 32'h0000_0001);
    check("t4_nobyp_rd2", rd2_n, 32'h0000_0001);
    step();
    drive(0, 0, 31, 31, 0, 32'h0, 32'h0);
    #1 check("t4_nobyp_after", rd2_n, 32'h0000_3008);
    step();

    drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
    step();
    valid_cycles = 0;
    for (int n = 1; n <= 31; n++) begin
      drive(0, 1, 5'(n), 5'(n - 1), 5'(n), 32'hA000_0000 + 32'(n), 32'(n * 4));
      step();
    end
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    step();
    check("t5_valid_cycles", 32'(valid_cycles), 32'd31);
    check("t5_count", wr_count_b, 32'd31);
    for (int n = 1; n < 32; n += 2) begin
      drive(0, 0, 5'(n), 5'(n + 1), 0, 32'h0, 32'h0);
      #1 check("t5_readback", rd1_b, 32'hA000_0000 + 32'(n));
      step();
    end

    for (int k = 0; k < 400; k++) begin
      logic [4:0] x3;
      x3 = 5'($urandom);
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) != 0) ? x3 : 5'($urandom),
            ($urandom_range(0, 2) == 0) ? x3 : 5'($urandom),
            x3, $urandom, $urandom);
      step();
    end

    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    force dut_b.wr_count = 32'hFFFF_FFFF;
    force dut_n.wr_count = 32'hFFFF_FFFF;
    #1 release dut_b.wr_count;
    release dut_n.wr_count;
    m_count = 32'hFFFF_FFFF;
    drive(0, 1, 3, 0, 3, 32'h5555_AAAA, 32'h100);
    step();
    drive(0, 0, 3, 0, 0, 32'h0, 32'h0);
    #1 check("t6_count", wr_count_b, 32'd0);
    check("t6_valid", {31'd0, wr_valid_b}, 32'd1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
